ps2_key_tracker: RTL and testbench
==================================

# ps2_key_tracker

Downstream consumer of the `ps2_keyboard` receiver FIFO. Pops scan-code bytes through the `ready`/`nextdata_n` handshake and decodes the E0/F0 prefix protocol into make/break events. Tracks the single currently held key and its ASCII value, and counts distinct key presses, ignoring typematic auto-repeat. Its outputs drive the HEX display/segment enables directly in `top`.

## Interface
- `CNT_W`, default 8: width of the press counter.
- `clk` input 1: system clock, the same clock as `ps2_keyboard`.
- `rst` input 1: reset, synchronous, active-high.
- `ready` input 1: receiver FIFO non-empty; `data` is valid.
- `data` input 8: FIFO head byte.
- `overflow` input 1: receiver FIFO overflow indication.
- `nextdata_n` output 1: active-low pop strobe to the FIFO. Low for exactly one cycle per byte consumed.
- `key_valid` output 1: a key is currently held; used as the display enable.
- `key_code` output 8: scan code of the held or last-held key.
- `key_ext` output 1: the held key was E0-prefixed.
- `key_ascii` output 8: ASCII value of `key_code`. 0 if `key_ext` or if the code is unmapped.
- `make_pulse` output 1: one-cycle pulse on each counted new press.
- `press_count` output CNT_W: number of counted presses. Wraps modulo 2^CNT_W.
- `ovf_seen` output 1: sticky; set once `overflow` is sampled high. Cleared only by `rst`.

## Operation
- Handshake FSM states are IDLE, POP and GAP.
  - IDLE with `ready`=1: latch and decode `data`, go to POP.
  - IDLE with `ready`=0: stay in IDLE.
  - POP: `nextdata_n`=0, go to GAP.
  - GAP: `nextdata_n`=1, `ready` and `data` are ignored while the FIFO pointer settles, go to IDLE.
- Prefix flags `ext_pend` and `brk_pend` are updated on each decoded byte:
  - 0xE0: set `ext_pend`. No other change.
  - 0xF0: set `brk_pend`. No other change.
  - Any other byte b with `brk_pend`=1 (break): if `key_valid` and b==`key_code` and `ext_pend`==`key_ext`, clear `key_valid`. Otherwise ignore the break. Then clear both flags.
  - Any other byte b with `brk_pend`=0 and (b,`ext_pend`) equal to the held key: auto-repeat. No output change. Clear the flags.
  - Any other byte b with `brk_pend`=0 otherwise (new make): load `key_code`=b and `key_ext`=`ext_pend`, set `key_valid`=1, load `key_ascii`, increment `press_count`, pulse `make_pulse`. Clear the flags.
- A new make while another key is held replaces the held key; last key wins.
- Repeated prefixes are idempotent. For example, F0 F0 1C behaves as F0 1C.
- Press counter arithmetic is unsigned and wraps from 2^CNT_W−1 to 0.
- Reset values:
  - `nextdata_n`=1.
  - All other outputs 0.
  - FSM in IDLE, both prefix flags cleared.
- `rst` in any state, including POP, returns to the reset values on the next edge. A byte that was not yet popped stays in the FIFO.

## Timing
- A byte is decoded on the rising edge that ends an IDLE cycle with `ready`=1.
- Latency from `ready` to the output update is 1 cycle.
- `make_pulse` is high for the single cycle after that edge.
- `nextdata_n` is low for the cycle after the decode edge.
- Maximum throughput is one byte per 3 cycles, which is far above the PS/2 byte rate.
- `ready` that drops during POP or GAP has no effect.
- `overflow` is sampled every cycle, independent of the FSM.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `ps2_pkg`:
  - Constants `PS2_BRK`=8'hF0 and `PS2_EXT`=8'hE0.
  - Handshake state enum.
- One sub-module, `ps2_ascii_rom`: combinational 8-bit scan code to 8-bit ASCII map (set 2, lowercase letters and digits, 0 for unmapped codes).
  - Its output is registered in `ps2_key_tracker` when `key_code` loads.
  - It replaces the standalone ROM lookup in `top`.

## Test plan
- Press and release of 'a' (bytes 1C, F0, 1C):
  - After 1C: `key_valid`=1, `key_code`=0x1C, `key_ascii`=0x61, `press_count`=1, one `make_pulse`.
  - After F0 1C: `key_valid`=0, `press_count` still 1.
- Auto-repeat (1C ×5, then F0 1C): `press_count`=1 and exactly one `make_pulse`.
- Extended key (E0 75, then E0 F0 75):
  - After E0 75: `key_ext`=1, `key_code`=0x75, `key_ascii`=0, `press_count`=1.
  - After E0 F0 75: `key_valid`=0.
  - A non-extended F0 75 while E0 75 is held leaves `key_valid`=1.
- Handshake with `ready` held high over 6 queued bytes:
  - `nextdata_n` low for exactly 1 cycle in every 3.
  - 6 pops total, with no pop while `ready`=0.
- Press counter wrap:
  - 256 alternating makes of 1C and 32 (each 1C then 32, no breaks) leave `press_count`=0.
  - `make_pulse` count is 256.
- Reset and overflow:
  - Assert `rst` during POP: next cycle `nextdata_n`=1 and all outputs are 0.
  - Pulse `overflow` for 1 cycle: `ovf_seen`=1 until the next `rst`.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard consumer logic.
//   PS2_BRK / PS2_EXT : break and extended prefix bytes of scan code set 2
//   hs_state_t        : FIFO pop handshake states
package ps2_pkg;

    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam logic [7:0] PS2_EXT = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_GAP  = 2'd2
    } hs_state_t;

endpackage

// File: rtl/ps2_ascii_rom.sv
// Combinational scan code (set 2) to ASCII map.
// Lowercase letters and digits are mapped; every other code maps to 0.
//   code  : 8-bit scan code
//   ascii : 8-bit ASCII value, 0 when unmapped
module ps2_ascii_rom (
    input  logic [7:0] code,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = 8'h00;
        case (code)
            8'h1C: ascii = 8'h61; // a
            8'h32: ascii = 8'h62; // b
            8'h21: ascii = 8'h63; // c
            8'h23: ascii = 8'h64; // d
            8'h24: ascii = 8'h65; // e
            8'h2B: ascii = 8'h66; // f
            8'h34: ascii = 8'h67; // g
            8'h33: ascii = 8'h68; // h
            8'h43: ascii = 8'h69; // i
            8'h3B: ascii = 8'h6A; // j
            8'h42: ascii = 8'h6B; // k
            8'h4B: ascii = 8'h6C; // l
            8'h3A: ascii = 8'h6D; // m
            8'h31: ascii = 8'h6E; // n
            8'h44: ascii = 8'h6F; // o
            8'h4D: ascii = 8'h70; // p
            8'h15: ascii = 8'h71; // q
            8'h2D: ascii = 8'h72; // r
            8'h1B: ascii = 8'h73; // s
            8'h2C: ascii = 8'h74; // t
            8'h3C: ascii = 8'h75; // u
            8'h2A: ascii = 8'h76; // v
            8'h1D: ascii = 8'h77; // w
            8'h22: ascii = 8'h78; // x
            8'h35: ascii = 8'h79; // y
            8'h1A: ascii = 8'h7A; // z
            8'h45: ascii = 8'h30; // 0
            8'h16: ascii = 8'h31; // 1
            8'h1E: ascii = 8'h32; // 2
            8'h26: ascii = 8'h33; // 3
            8'h25: ascii = 8'h34; // 4
            8'h2E: ascii = 8'h35; // 5
            8'h36: ascii = 8'h36; // 6
            8'h3D: ascii = 8'h37; // 7
            8'h3E: ascii = 8'h38; // 8
            8'h46: ascii = 8'h39; // 9
            default: ascii = 8'h00;
        endcase
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// Pops scan-code bytes from the PS/2 receiver FIFO and tracks the held key.
// Decodes E0/F0 prefixes into make/break events, keeps the single held key
// (last make wins), its ASCII value, and a count of distinct presses that
// ignores typematic auto-repeat.
//   clk, rst     : clock, synchronous active-high reset
//   ready, data  : FIFO non-empty flag and head byte
//   overflow     : FIFO overflow indication (sticky-captured in ovf_seen)
//   nextdata_n   : active-low pop strobe, one cycle per byte consumed
//   key_valid    : a key is held
//   key_code     : scan code of held / last-held key
//   key_ext      : held key was E0-prefixed
//   key_ascii    : ASCII of key_code, 0 if extended or unmapped
//   make_pulse   : one-cycle pulse per counted press
//   press_count  : counted presses, wraps modulo 2^CNT_W
//   ovf_seen     : overflow was observed since reset
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ready,
    input  logic [7:0]       data,
    input  logic             overflow,
    output logic             nextdata_n,
    output logic             key_valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic [7:0]       key_ascii,
    output logic             make_pulse,
    output logic [CNT_W-1:0] press_count,
    output logic             ovf_seen
);

    hs_state_t  state_reg;
    logic       ext_pend_reg;
    logic       brk_pend_reg;
    logic [7:0] rom_ascii;
    logic       held_match;

    // The ROM looks up the incoming byte so its result can be registered
    // in the same edge that loads key_code.
    ps2_ascii_rom u_rom (
        .code  (data),
        .ascii (rom_ascii)
    );

    // Byte (with pending extension) names the key currently held.
    assign held_match = key_valid && (data == key_code) && (ext_pend_reg == key_ext);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            ext_pend_reg <= 1'b0;
            brk_pend_reg <= 1'b0;
            nextdata_n   <= 1'b1;
            key_valid    <= 1'b0;
            key_code     <= 8'h00;
            key_ext      <= 1'b0;
            key_ascii    <= 8'h00;
            make_pulse   <= 1'b0;
            press_count  <= '0;
            ovf_seen     <= 1'b0;
        end else begin
            make_pulse <= 1'b0;
            ovf_seen   <= ovf_seen | overflow;
            case (state_reg)
                ST_IDLE: begin
                    if (ready) begin
                        state_reg  <= ST_POP;
                        nextdata_n <= 1'b0;
                        if (data == PS2_EXT) begin
                            ext_pend_reg <= 1'b1;
                        end else if (data == PS2_BRK) begin
                            brk_pend_reg <= 1'b1;
                        end else begin
                            ext_pend_reg <= 1'b0;
                            brk_pend_reg <= 1'b0;
                            if (brk_pend_reg) begin
                                // Breaks for keys other than the held one are ignored.
                                if (held_match) begin
                                    key_valid <= 1'b0;
                                end
                            end else if (!held_match) begin
                                // New make; a repeat of the held key changes nothing.
                                key_valid   <= 1'b1;
                                key_code    <= data;
                                key_ext     <= ext_pend_reg;
                                key_ascii   <= ext_pend_reg ? 8'h00 : rom_ascii;
                                press_count <= press_count + CNT_W'(1);
                                make_pulse  <= 1'b1;
                            end
                        end
                    end
                end
                ST_POP: begin
                    nextdata_n <= 1'b1;
                    state_reg  <= ST_GAP;
                end
                // FIFO head is still settling; inputs ignored for one cycle.
                ST_GAP: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
module tb_ps2_key_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data = 8'h00;
    logic       overflow = 1'b0;
    logic       nextdata_n;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic [7:0] key_ascii;
    logic       make_pulse;
    logic [7:0] press_count;
    logic       ovf_seen;

    int checks = 0;
    int failures = 0;
    int pops = 0;
    int pulses = 0;
    int tick_n = 0;
    logic [7:0] fifo[$];
    int pop_ticks[$];

    ps2_key_tracker #(.CNT_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .ready       (ready),
        .data        (data),
        .overflow    (overflow),
        .nextdata_n  (nextdata_n),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ext     (key_ext),
        .key_ascii   (key_ascii),
        .make_pulse  (make_pulse),
        .press_count (press_count),
        .ovf_seen    (ovf_seen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle of the FIFO model, evaluated at the falling edge.
    task automatic tick();
        @(negedge clk);
        tick_n++;
        if (make_pulse === 1'b1) pulses++;
        if (nextdata_n === 1'b0) begin
            pops++;
            pop_ticks.push_back(tick_n);
            check("pop_nonempty", (fifo.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (fifo.size() > 0) void'(fifo.pop_front());
        end
        ready = (fifo.size() > 0);
        data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
    endtask

    task automatic drain();
        int guard = 0;
        while (fifo.size() > 0 && guard < 5000) begin
            tick();
            guard++;
        end
        check("drain_timeout", (guard < 5000) ? 32'd1 : 32'd0, 32'd1);
        repeat (3) tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ready = 1'b0;
        fifo.delete();
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        pops = 0;
        pop_ticks.delete();
    endtask

    initial begin
        do_reset();
        $display("reset: checking reset values");
        check("rst_nextdata_n", nextdata_n, 1);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_code", key_code, 0);
        check("rst_key_ext", key_ext, 0);
        check("rst_key_ascii", key_ascii, 0);
        check("rst_make_pulse", make_pulse, 0);
        check("rst_press_count", press_count, 0);
        check("rst_ovf_seen", ovf_seen, 0);

        // Press and release 'a'
        fifo.push_back(8'h1C);
        drain();
        $display("txn: make 1C code=%0h ascii=%0h count=%0d", key_code, key_ascii, press_count);
        check("a_valid", key_valid, 1);
        check("a_code", key_code, 8'h1C);
        check("a_ascii", key_ascii, 8'h61);
        check("a_count", press_count, 1);
        check("a_pulses", pulses, 1);
        fifo.push_back(8'hF0); fifo.push_back(8'h1C);
        drain();
        $display("txn: break 1C valid=%0d count=%0d", key_valid, press_count);
        check("a_brk_valid", key_valid, 0);
        check("a_brk_count", press_count, 1);

        // Auto-repeat
        do_reset();
        repeat (5) fifo.push_back(8'h1C);
        fifo.push_back(8'hF0); fifo.push_back(8'h1C);
        drain();
        $display("txn: autorepeat count=%0d pulses=%0d", press_count, pulses);
        check("rep_count", press_count, 1);
        check("rep_pulses", pulses, 1);
        check("rep_valid", key_valid, 0);

        // Extended key
        do_reset();
        fifo.push_back(8'hE0); fifo.push_back(8'h75);
        drain();
        $display("txn: make E0 75 ext=%0d code=%0h", key_ext, key_code);
        check("ext_ext", key_ext, 1);
        check("ext_code", key_code, 8'h75);
        check("ext_ascii", key_ascii, 0);
        check("ext_count", press_count, 1);
        check("ext_valid", key_valid, 1);
        fifo.push_back(8'hF0); fifo.push_back(8'h75);
        drain();
        $display("txn: plain break 75 valid=%0d", key_valid);
        check("ext_plainbrk_valid", key_valid, 1);
        fifo.push_back(8'hE0); fifo.push_back(8'hF0); fifo.push_back(8'h75);
        drain();
        $display("txn: break E0 75 valid=%0d", key_valid);
        check("ext_brk_valid", key_valid, 0);
        check("ext_brk_count", press_count, 1);

        // Handshake with 6 queued bytes
        do_reset();
        fifo.push_back(8'h1C); fifo.push_back(8'h32); fifo.push_back(8'h21);
        fifo.push_back(8'h23); fifo.push_back(8'h24); fifo.push_back(8'h2B);
        drain();
        $display("txn: handshake pops=%0d count=%0d code=%0h", pops, press_count, key_code);
        check("hs_pops", pops, 6);
        for (int i = 1; i < pop_ticks.size(); i++)
            check("hs_spacing", pop_ticks[i] - pop_ticks[i-1], 3);
        check("hs_count", press_count, 6);
        check("hs_code", key_code, 8'h2B);
        check("hs_ascii", key_ascii, 8'h66);
        // Repeated break prefix is idempotent
        fifo.push_back(8'hF0); fifo.push_back(8'hF0); fifo.push_back(8'h2B);
        drain();
        $display("txn: F0 F0 2B valid=%0d", key_valid);
        check("dblbrk_valid", key_valid, 0);
        check("dblbrk_count", press_count, 6);

        // Counter wrap
        do_reset();
        for (int i = 0; i < 128; i++) begin
            fifo.push_back(8'h1C); fifo.push_back(8'h32);
        end
        drain();
        $display("txn: wrap count=%0d pulses=%0d", press_count, pulses);
        check("wrap_count", press_count, 0);
        check("wrap_pulses", pulses, 256);
        check("wrap_code", key_code, 8'h32);

        // Reset during POP
        do_reset();
        @(negedge clk);
        ready = 1'b1; data = 8'h1C;
        @(negedge clk);
        ready = 1'b0;
        check("pop_state_nextdata_n", nextdata_n, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("txn: reset in POP nextdata_n=%0d valid=%0d", nextdata_n, key_valid);
        check("rstpop_nextdata_n", nextdata_n, 1);
        check("rstpop_valid", key_valid, 0);
        check("rstpop_code", key_code, 0);
        check("rstpop_count", press_count, 0);
        check("rstpop_ascii", key_ascii, 0);

        // Overflow sticky
        @(negedge clk);
        check("ovf_before", ovf_seen, 0);
        overflow = 1'b1;
        @(negedge clk);
        overflow = 1'b0;
        check("ovf_set", ovf_seen, 1);
        repeat (5) @(negedge clk);
        $display("txn: overflow sticky ovf_seen=%0d", ovf_seen);
        check("ovf_sticky", ovf_seen, 1);
        do_reset();
        check("ovf_cleared", ovf_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
